// File: rtl/nibble_serial_addsub.sv
// Serial add/subtract unit: one 4-bit carry-lookahead slice per clock,
// LSB nibble first, with unsigned carry/borrow and signed overflow flags.
module nibble_serial_addsub #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow
);

   localparam int NIB = WIDTH / 4;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIB - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             cin;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [3:0]       na;
   logic [3:0]       nb;
   logic [3:0]       g;
   logic [3:0]       p;
   logic [4:0]       c;
   logic [3:0]       sum;
   logic             last;

   // One nibble of carry-lookahead add, fed by the registered carry.
   always_comb begin
      a_sh = op_a >> {cnt, 2'b00};
      b_sh = op_b >> {cnt, 2'b00};
      na   = a_sh[3:0];
      nb   = b_sh[3:0];
      g    = na & nb;
      p    = na ^ nb;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
      sum  = p ^ c[3:0];
      last = (cnt == LAST);
   end

   // Control FSM; subtract is a + ~b + 1, so mode seeds the carry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         op_a     <= '0;
         op_b     <= '0;
         cin      <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  op_a  <= a;
                  op_b  <= mode ? ~b : b;
                  cin   <= mode;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               result[{cnt, 2'b00} +: 4] <= sum;
               cin <= c[4];
               if (last) begin
                  carry    <= c[4];
                  overflow <= c[3] ^ c[4];
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Scoreboard bench for nibble_serial_addsub (WIDTH=16):
// directed vectors, monitor pops expected results on done.
module tb_nibble_serial_addsub;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        carry;
   logic        overflow;

   int checks = 0;
   int failures = 0;

   logic [17:0] sb[$];

   nibble_serial_addsub #(.WIDTH(16)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .mode(mode),
      .a(a),
      .b(b),
      .busy(busy),
      .done(done),
      .result(result),
      .carry(carry),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            logic [17:0] e;
            e = sb.pop_front();
            check("result", int'(result), int'(e[17:2]));
            check("carry", int'(carry), int'(e[1]));
            check("overflow", int'(overflow), int'(e[0]));
         end
      end
   end

   task automatic do_op(input logic [15:0] av, input logic [15:0] bv,
                        input logic m, input logic [15:0] er,
                        input logic ec, input logic ev,
                        input bit disturb);
      int busy_n;
      int done_at;
      busy_n = 0;
      done_at = 0;
      @(negedge clk);
      a = av;
      b = bv;
      mode = m;
      start = 1'b1;
      @(posedge clk);
      sb.push_back({er, ec, ev});
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (busy) busy_n++;
         if (done && done_at == 0) done_at = i;
         if (i == 1) begin
            start = 1'b0;
            a = ~av;
            b = ~bv;
            mode = ~m;
         end
         if (disturb && i == 2) begin
            start = 1'b1;
            a = 16'hFFFF;
            b = 16'hFFFF;
         end
         if (disturb && i == 3) start = 1'b0;
      end
      check("latency", done_at, 5);
      check("busy_cycles", busy_n, 4);
      check("hold_result", int'(result), int'(er));
      check("hold_carry", int'(carry), int'(ec));
      check("hold_overflow", int'(overflow), int'(ev));
   endtask

   logic [15:0] bb_a[4] = '{16'h0100, 16'h0003, 16'hF000, 16'h8000};
   logic [15:0] bb_b[4] = '{16'h0200, 16'h0004, 16'h1000, 16'h8000};
   logic        bb_m[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   logic [17:0] bb_e[4] = '{{16'h0300, 2'b00}, {16'hFFFF, 2'b00},
                            {16'h0000, 2'b10}, {16'h0000, 2'b10}};

   initial begin
      #3 rst = 1'b1;
      #1;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_result", int'(result), 0);
      check("rst_cc", int'({carry, overflow}), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      do_op(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0);
      do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
      do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
      do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
      do_op(16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
      do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
      do_op(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1);

      // Abort in the second RUN cycle.
      @(negedge clk);
      a = 16'h1234;
      b = 16'h1111;
      mode = 1'b0;
      start = 1'b1;
      @(posedge clk);
      sb.push_back({16'h2345, 2'b00});
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("pre_abort_busy", int'(busy), 1);
      #2 rst = 1'b1;
      void'(sb.pop_back());
      #1;
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_result", int'(result), 0);
      check("abort_cc", int'({carry, overflow}), 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("abort_no_done", int'(done), 0);
      end
      rst = 1'b0;
      do_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

      // start held high: accepts every 6 cycles, junk in between.
      @(negedge clk);
      for (int k = 0; k < 26; k++) begin
         start = (k < 20);
         if (k % 6 == 0 && k < 20) begin
            a = bb_a[k / 6];
            b = bb_b[k / 6];
            mode = bb_m[k / 6];
         end else begin
            a = 16'hDEAD;
            b = 16'hBEEF;
            mode = k[0];
         end
         @(posedge clk);
         if (k % 6 == 0 && k < 20) sb.push_back(bb_e[k / 6]);
         @(negedge clk);
         check("b2b_done", int'(done), int'(k % 6 == 4 && k <= 22));
      end
      start = 1'b0;

      repeat (3) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/nibble_serial_addsub.md
NIBBLE_SERIAL_ADDSUB -- requirements
Module: nibble_serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width; SHALL be a multiple of 4 and at least 8.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin an operation.
REQ-005 SHALL have port mode, input, 1, operation select: 0 add, 1 subtract.
REQ-006 SHALL have port a, input, WIDTH, first operand (minuend in subtract).
REQ-007 SHALL have port b, input, WIDTH, second operand (subtrahend in subtract).
REQ-008 SHALL have port busy, output, 1, high while nibbles are being processed.
REQ-009 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port result, output, WIDTH, sum or difference.
REQ-011 SHALL have port carry, output, 1, carry out of MSB; in subtract, 1 = no borrow (a >= b unsigned).
REQ-012 SHALL have port overflow, output, 1, two's-complement signed overflow.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-014 SHALL accept start only in IDLE; start in RUN or DONE SHALL be ignored with no effect on the operation in progress.
REQ-015 On the edge accepting start: capture a, mode, and b (bitwise inverted when mode=1); set internal carry to mode; clear nibble counter; go to RUN.
REQ-016 Operands captured on the accepting edge SHALL be used for the whole operation; later changes on a, b, mode SHALL NOT affect it.
REQ-017 In RUN, each edge SHALL compute one 4-bit slice, LSB nibble first, using 4-bit carry-lookahead (generate/propagate) logic with the registered carry as carry-in, write the slice into result, and register the slice carry-out for the next nibble.
REQ-018 SHALL take exactly WIDTH/4 RUN edges; on the last, carry SHALL load the final carry-out, overflow SHALL load carry-into-MSB XOR carry-out-of-MSB, and the FSM SHALL go to DONE.
REQ-019 busy SHALL be 1 exactly while in RUN; done SHALL be 1 exactly while in DONE; DONE SHALL last one cycle, then return to IDLE.
REQ-020 Latency: with start sampled at edge E0, done SHALL be high in the cycle after edge E0+WIDTH/4 (cycle after E4 for WIDTH=16).
REQ-021 result, carry, overflow SHALL hold their final values from DONE through IDLE until the next accepted start; during RUN, result bits above the current nibble are don't-care.
REQ-022 Nibble counter SHALL be ceil(log2(WIDTH/4)) bits wide and SHALL NOT wrap during an operation.
REQ-023 start held high continuously SHALL yield back-to-back operations, one accepted per IDLE cycle (period WIDTH/4+2 cycles).

Reset
REQ-024 rst high SHALL immediately, independent of clk, force state IDLE, counter 0, busy 0, done 0, result 0, carry 0, overflow 0.
REQ-025 rst asserted mid-RUN SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be processed normally.

Verification
REQ-026 add, a=0x1234, b=0x0FCD -> done in cycle after E4, result=0x2201, carry=0, overflow=0, busy high exactly 4 cycles.
REQ-027 add, a=0xFFFF, b=0x0001 -> result=0x0000, carry=1, overflow=0; add a=0x7FFF, b=0x0001 -> result=0x8000, carry=0, overflow=1.
REQ-028 sub, a=0x0005, b=0x0007 -> result=0xFFFE, carry=0, overflow=0; sub a=0x8000, b=0x0001 -> result=0x7FFF, carry=1, overflow=1.
REQ-029 start pulsed again during RUN with different operands -> ignored; result matches first operands; exactly one done pulse.
REQ-030 rst asserted at 2nd RUN cycle -> all outputs 0 asynchronously, no done; subsequent add 0x0001+0x0001 -> result=0x0002.
REQ-031 start held high for 20 cycles, operands changed each op -> done every 6 cycles, each result correct for operands captured at its own accepting edge.
